prod_accum: RTL and testbench

Downstream consumer of the 8x8 unsigned multiplier stage: takes its 16-bit product stream, sums a frame of products, and presents the sum as a dot-product result. It uses a valid/ready handshake on both sides. It terminates a frame on an explicit last-marker or when a term-count limit is reached. Overflow is reported and the sum saturates.

---
 rtl/prod_accum_pkg.sv | 23 ++
 rtl/prod_accum_sat_add.sv | 25 ++
 rtl/prod_accum.sv | 123 ++++++++++++
 tb/tb_prod_accum.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/prod_accum_pkg.sv
// Shared types and default sizing for the product accumulator.
package prod_accum_pkg;

    // Default product width (matches 8x8 multiplier output).
    localparam int unsigned DEF_P_W       = 16;
    // Default accumulator width; must be >= product width.
    localparam int unsigned DEF_ACC_W     = 24;
    // Default maximum products per frame.
    localparam int unsigned DEF_MAX_TERMS = 16;

    // Accumulator FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Width needed to hold a term count from 0 to max_terms inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/prod_accum_sat_add.sv
// Unsigned saturating add of an ACC_W accumulator and a P_W addend.
//   a     : accumulator operand (ACC_W)
//   b     : addend, zero-extended (P_W)
//   sum   : a + b, clamped to all-ones on carry out (ACC_W)
//   carry : carry out of the ACC_W-bit add
module prod_accum_sat_add #(
    parameter int unsigned P_W   = 16,
    parameter int unsigned ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [P_W-1:0]   b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] full;

    // One extra bit catches the carry; b is never sign-extended.
    always_comb begin
        full  = {1'b0, a} + (ACC_W+1)'(b);
        carry = full[ACC_W];
        sum   = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
    end

endmodule

// File: rtl/prod_accum.sv
// Frame accumulator for the multiplier product stream: sums a frame of
// unsigned products (ended by p_last or MAX_TERMS beats) and holds the
// saturating sum until the consumer takes it.
//   clk, rst          : clock, synchronous active-low reset
//   p_in/p_valid/p_last, in_ready : product input handshake
//   acc_out/acc_cnt/acc_ovf, acc_valid, out_ready : result handshake
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter  int unsigned P_W       = DEF_P_W,
    parameter  int unsigned ACC_W     = DEF_ACC_W,
    parameter  int unsigned MAX_TERMS = DEF_MAX_TERMS,
    localparam int unsigned CNT_W     = cnt_width(MAX_TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P_W-1:0]   p_in,
    input  logic             p_valid,
    input  logic             p_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             acc_ovf
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    prod_accum_sat_add #(
        .P_W   (P_W),
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a     (acc_q),
        .b     (p_in),
        .sum   (sum),
        .carry (carry)
    );

    // Ready only out of reset and while not holding a result (no bypass).
    assign in_ready = rst & (state_q != HOLD);
    assign accept   = p_valid & in_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = ACC_W'(p_in);
                    cnt_d = CNT_W'(1);
                    ovf_d = 1'b0;
                    if (p_last || (MAX_TERMS == 1)) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    // Saturated value plus anything carries again, so it sticks.
                    acc_d = sum;
                    ovf_d = ovf_q | carry;
                    cnt_d = cnt_inc;
                    if (p_last || (cnt_inc == CNT_W'(MAX_TERMS))) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign acc_out   = acc_q;
    assign acc_cnt   = cnt_q;
    assign acc_ovf   = ovf_q;
    assign acc_valid = valid_q;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: a 24-bit and an 18-bit accumulator
// share one input stream and are compared against a frame-level model.
module tb_prod_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] p_in;
    logic        p_valid;
    logic        p_last;
    logic        out_ready;

    logic        in_ready,  in_ready18;
    logic [23:0] acc_out;
    logic [17:0] acc_out18;
    logic        acc_valid, acc_valid18;
    logic [4:0]  acc_cnt,   acc_cnt18;
    logic        acc_ovf,   acc_ovf18;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    prod_accum u_dut (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
        .in_ready(in_ready), .acc_out(acc_out), .acc_valid(acc_valid),
        .out_ready(out_ready), .acc_cnt(acc_cnt), .acc_ovf(acc_ovf)
    );

    prod_accum #(.ACC_W(18)) u_dut18 (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
        .in_ready(in_ready18), .acc_out(acc_out18), .acc_valid(acc_valid18),
        .out_ready(out_ready), .acc_cnt(acc_cnt18), .acc_ovf(acc_ovf18)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for one edge, then drop p_valid/p_last.
    task automatic send(input logic [15:0] v, input logic last);
        p_in    = v;
        p_valid = 1'b1;
        p_last  = last;
        tick();
        p_valid = 1'b0;
        p_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; p_valid = 1'b1; p_in = 16'hFFFF; p_last = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vec++; if (acc_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b want 0", acc_valid); end
        vec++; if (acc_out !== 24'd0) begin err++; $display("FAIL reset_acc: got %0d want 0", acc_out); end
        vec++; if (acc_cnt !== 5'd0) begin err++; $display("FAIL reset_cnt: got %0d want 0", acc_cnt); end
        vec++; if (acc_ovf !== 1'b0) begin err++; $display("FAIL reset_ovf: got %b want 0", acc_ovf); end
        rst = 1'b1; p_valid = 1'b0;
        #1;
        vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(16'd0, 1'b0);
        send(16'd1, 1'b0);
        send(16'd125, 1'b1);
        vec++; if (acc_valid !== 1'b1) begin err++; $display("FAIL basic_valid: got %b want 1", acc_valid); end
        vec++; if (acc_out !== 24'd126) begin err++; $display("FAIL basic_acc: got %0d want 126", acc_out); end
        vec++; if (acc_cnt !== 5'd3) begin err++; $display("FAIL basic_cnt: got %0d want 3", acc_cnt); end
        vec++; if (acc_ovf !== 1'b0) begin err++; $display("FAIL basic_ovf: got %b want 0", acc_ovf); end
        tick();
        out_ready = 1'b0;
        vec++; if (acc_valid !== 1'b0 || acc_cnt !== 5'd0 || in_ready !== 1'b1)
            begin err++; $display("FAIL basic_idle: got valid=%b cnt=%0d rdy=%b want 0 0 1", acc_valid, acc_cnt, in_ready); end
    endtask

    task automatic test_count_limit();
        out_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL limit_ready beat %0d: got %b want 1", k, in_ready); end
            send(16'd65025, 1'b0);
            vec++; if (acc_ovf18 !== (k >= 5)) begin err++; $display("FAIL limit_ovf18 beat %0d: got %b want %b", k, acc_ovf18, (k >= 5)); end
            vec++; if (acc_valid !== (k == 16)) begin err++; $display("FAIL limit_valid beat %0d: got %b want %b", k, acc_valid, (k == 16)); end
        end
        vec++; if (acc_out !== 24'd1040400) begin err++; $display("FAIL limit_acc: got %0d want 1040400", acc_out); end
        vec++; if (acc_cnt !== 5'd16 || acc_ovf !== 1'b0) begin err++; $display("FAIL limit_cnt_ovf: got %0d %b want 16 0", acc_cnt, acc_ovf); end
        vec++; if (acc_out18 !== 18'd262143) begin err++; $display("FAIL limit_acc18: got %0d want 262143", acc_out18); end
        vec++; if (acc_cnt18 !== 5'd16 || acc_valid18 !== 1'b1) begin err++; $display("FAIL limit_cnt18: got %0d %b want 16 1", acc_cnt18, acc_valid18); end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(16'd625, 1'b0);
        send(16'd625, 1'b1);
        p_valid = 1'b1; p_in = 16'd9;
        repeat (5) begin
            vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL bp_ready: got %b want 0", in_ready); end
            tick();
            vec++; if (acc_out !== 24'd1250 || acc_valid !== 1'b1) begin err++; $display("FAIL bp_hold: got %0d %b want 1250 1", acc_out, acc_valid); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vec++; if (acc_valid !== 1'b0 || in_ready !== 1'b1) begin err++; $display("FAIL bp_release: got valid=%b rdy=%b want 0 1", acc_valid, in_ready); end
        tick();
        p_valid = 1'b0;
        vec++; if (acc_out !== 24'd9 || acc_cnt !== 5'd1) begin err++; $display("FAIL bp_next_first: got %0d cnt %0d want 9 1", acc_out, acc_cnt); end
        send(16'd0, 1'b1);
        vec++; if (acc_out !== 24'd9 || acc_cnt !== 5'd2 || acc_valid !== 1'b1) begin err++; $display("FAIL bp_next_frame: got %0d cnt %0d v %b want 9 2 1", acc_out, acc_cnt, acc_valid); end
        drain();
    endtask

    task automatic test_single();
        p_valid = 1'b0; p_last = 1'b1; p_in = 16'd500;
        tick();
        p_last = 1'b0;
        vec++; if (acc_valid !== 1'b0 || acc_cnt !== 5'd0 || in_ready !== 1'b1) begin err++; $display("FAIL lone_last: got v=%b cnt=%0d rdy=%b want 0 0 1", acc_valid, acc_cnt, in_ready); end
        send(16'd625, 1'b1);
        vec++; if (acc_out !== 24'd625 || acc_cnt !== 5'd1 || acc_valid !== 1'b1) begin err++; $display("FAIL single: got %0d cnt %0d v %b want 625 1 1", acc_out, acc_cnt, acc_valid); end
        drain();
    endtask

    task automatic test_reset_mid();
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        rst = 1'b0;
        tick();
        vec++; if (acc_valid !== 1'b0 || acc_out !== 24'd0 || acc_cnt !== 5'd0 || acc_ovf !== 1'b0 || in_ready !== 1'b0)
            begin err++; $display("FAIL midreset: got v=%b acc=%0d cnt=%0d ovf=%b rdy=%b want all 0", acc_valid, acc_out, acc_cnt, acc_ovf, in_ready); end
        rst = 1'b1;
        send(16'd7, 1'b1);
        vec++; if (acc_out !== 24'd7 || acc_cnt !== 5'd1 || acc_valid !== 1'b1) begin err++; $display("FAIL midreset_new: got %0d cnt %0d v %b want 7 1 1", acc_out, acc_cnt, acc_valid); end
        drain();
    endtask

    // Random frames: model sums in wide arithmetic and clamps afterwards.
    task automatic test_random();
        longint sum, max24, max18, e24, e18;
        int     last_at, n;
        logic [15:0] v;
        max24 = (64'd1 << 24) - 1;
        max18 = (64'd1 << 18) - 1;
        for (int f = 0; f < 25; f++) begin
            last_at = $urandom_range(1, 20);
            n       = (last_at > 16) ? 16 : last_at;
            sum     = 0;
            for (int k = 1; k <= n; k++) begin
                while ($urandom_range(0, 3) == 0) begin
                    p_last = 1'($urandom_range(0, 1));
                    tick();
                    p_last = 1'b0;
                end
                v = ($urandom_range(0, 2) == 0) ? 16'd65025
                    : 16'($urandom_range(0, 255) * $urandom_range(0, 255));
                sum += longint'(v);
                send(v, (k == last_at));
            end
            e24 = (sum > max24) ? max24 : sum;
            e18 = (sum > max18) ? max18 : sum;
            repeat ($urandom_range(0, 3)) tick();
            vec++; if (acc_valid !== 1'b1 || acc_cnt !== 5'(n) || acc_out !== 24'(e24) || acc_ovf !== (sum > max24))
                begin err++; $display("FAIL rand24 frame %0d: got v=%b cnt=%0d acc=%0d ovf=%b want 1 %0d %0d %b", f, acc_valid, acc_cnt, acc_out, acc_ovf, n, e24, (sum > max24)); end
            vec++; if (acc_valid18 !== 1'b1 || acc_cnt18 !== 5'(n) || acc_out18 !== 18'(e18) || acc_ovf18 !== (sum > max18))
                begin err++; $display("FAIL rand18 frame %0d: got v=%b cnt=%0d acc=%0d ovf=%b want 1 %0d %0d %b", f, acc_valid18, acc_cnt18, acc_out18, acc_ovf18, n, e18, (sum > max18)); end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_count_limit();
        test_backpressure();
        test_single();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
